// File: rtl/shift_engine_if.sv
// Handshake and data bundle between a shift_engine and its controller.
interface shift_engine_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = $clog2(WIDTH) + 1
);
  logic             ld;
  logic [WIDTH-1:0] par_in;
  logic             start;
  logic [AMT_W-1:0] amt;
  logic [2:0]       mode;
  logic             step;
  logic             ser_in;
  logic [WIDTH-1:0] par_out;
  logic             ser_out;
  logic             MSB_out;
  logic             LSB_out;
  logic             busy;
  logic             done;

  modport master (
    output ld, par_in, start, amt, mode, step, ser_in,
    input  par_out, ser_out, MSB_out, LSB_out, busy, done
  );

  modport slave (
    input  ld, par_in, start, amt, mode, step, ser_in,
    output par_out, ser_out, MSB_out, LSB_out, busy, done
  );
endinterface

// File: rtl/shift_engine.sv
// Multi-mode shift register: parallel load, programmed shift sequences
// (LSL/LSR/ASR/ROL/ROR/hold) with start/busy/done, and idle single-step.
module shift_engine #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
  input logic           clk,
  input logic           rst,
  shift_engine_if.slave bus
);

  localparam logic [2:0] M_LSL = 3'b000;
  localparam logic [2:0] M_LSR = 3'b001;
  localparam logic [2:0] M_ASR = 3'b010;
  localparam logic [2:0] M_ROL = 3'b011;
  localparam logic [2:0] M_ROR = 3'b100;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ser_q, ser_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [2:0]       sh_mode;
  logic [WIDTH-1:0] sh_data;
  logic             sh_ser;

  // Running sequences use the latched mode; idle steps use the live mode.
  assign sh_mode = (state_q == SHIFT) ? mode_q : bus.mode;

  // One-position shift of the current register; hold codes leave both unchanged.
  always_comb begin
    sh_data = data_q;
    sh_ser  = ser_q;
    case (sh_mode)
      M_LSL: begin sh_data = {data_q[WIDTH-2:0], bus.ser_in};    sh_ser = data_q[WIDTH-1]; end
      M_LSR: begin sh_data = {bus.ser_in, data_q[WIDTH-1:1]};    sh_ser = data_q[0];       end
      M_ASR: begin sh_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]}; sh_ser = data_q[0];     end
      M_ROL: begin sh_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]}; sh_ser = data_q[WIDTH-1]; end
      M_ROR: begin sh_data = {data_q[0], data_q[WIDTH-1:1]};     sh_ser = data_q[0];       end
      default: ;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ser_d   = ser_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ld) begin
          data_d = bus.par_in;
        end else if (bus.start) begin
          mode_d = bus.mode;
          cnt_d  = bus.amt;
          if (bus.amt != '0) begin
            state_d = SHIFT;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else if (bus.step) begin
          data_d = sh_data;
          ser_d  = sh_ser;
        end
      end
      SHIFT: begin
        data_d = sh_data;
        ser_d  = sh_ser;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      ser_q   <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ser_q   <= ser_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.par_out = data_q;
  assign bus.ser_out = ser_q;
  assign bus.MSB_out = data_q[WIDTH-1];
  assign bus.LSB_out = data_q[0];
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_shift_engine.sv
// Randomized self-checking bench for shift_engine against an arithmetic reference model.
module tb_shift_engine;
  localparam int unsigned W     = 8;
  localparam int unsigned AMT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_engine_if #(.WIDTH(W), .AMT_W(AMT_W)) bus ();
  shift_engine #(.WIDTH(W), .AMT_W(AMT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] m_data;
  logic         m_ser;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: one shift computed with integer arithmetic on the model state.
  function automatic void ref_shift(input logic [2:0] m, input logic si);
    int d, nd, top;
    d   = int'(m_data);
    top = 1 << (W - 1);
    nd  = d;
    case (m)
      3'd0: begin nd = ((d * 2) + int'(si)) % (1 << W);   m_ser = (d / top) != 0; end
      3'd1: begin nd = (d / 2) + (si ? top : 0);         m_ser = (d % 2) != 0;   end
      3'd2: begin nd = (d / 2) + (d & top);              m_ser = (d % 2) != 0;   end
      3'd3: begin nd = ((d * 2) % (1 << W)) + (d / top); m_ser = (d / top) != 0; end
      3'd4: begin nd = (d / 2) + ((d % 2) * top);        m_ser = (d % 2) != 0;   end
      default: ;
    endcase
    m_data = W'(nd);
  endfunction

  task automatic check_state(input string tag, input logic eb, input logic ed);
    check_eq({tag, "_data"}, 32'(bus.par_out), 32'(m_data));
    check_eq({tag, "_ser"},  32'(bus.ser_out), 32'(m_ser));
    check_eq({tag, "_busy"}, 32'(bus.busy),    32'(eb));
    check_eq({tag, "_done"}, 32'(bus.done),    32'(ed));
    check_eq({tag, "_msb"},  32'(bus.MSB_out), 32'(m_data[W-1]));
    check_eq({tag, "_lsb"},  32'(bus.LSB_out), 32'(m_data[0]));
  endtask

  task automatic idle_inputs();
    bus.ld     = 1'b0;
    bus.start  = 1'b0;
    bus.step   = 1'b0;
    bus.par_in = W'($urandom);
    bus.amt    = AMT_W'($urandom);
    bus.mode   = 3'($urandom);
    bus.ser_in = 1'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_data = '0;
    m_ser  = 1'b0;
    check_state("reset", 1'b0, 1'b0);
  endtask

  task automatic do_load(input logic [W-1:0] v, input logic with_start);
    bus.ld     = 1'b1;
    bus.par_in = v;
    bus.start  = with_start;
    bus.amt    = AMT_W'($urandom_range(1, 8));
    tick();
    idle_inputs();
    m_data = v;
    check_state("load", 1'b0, 1'b0);
    if (with_start) begin
      tick();
      check_state("load_nostart", 1'b0, 1'b0);
    end
  endtask

  task automatic do_step(input logic [2:0] m);
    logic si;
    si = 1'($urandom);
    bus.step   = 1'b1;
    bus.mode   = m;
    bus.ser_in = si;
    tick();
    idle_inputs();
    ref_shift(m, si);
    check_state("step", 1'b0, 1'b0);
  endtask

  // fill < 0 draws a random serial bit per shift; disturb drives ignored requests mid-sequence.
  task automatic run_seq(input logic [2:0] m, input int a, input int fill, input bit disturb);
    logic si;
    bus.start  = 1'b1;
    bus.mode   = m;
    bus.amt    = AMT_W'(a);
    bus.ser_in = 1'($urandom);
    tick();
    idle_inputs();
    if (a == 0) check_state("seq_zero", 1'b0, 1'b1);
    else        check_state("seq_go",   1'b1, 1'b0);
    for (int k = 1; k <= a; k++) begin
      si = (fill < 0) ? 1'($urandom) : 1'(fill);
      bus.ser_in = si;
      if (disturb) begin
        bus.ld     = 1'b1;
        bus.par_in = W'(8'h55);
        bus.start  = 1'b1;
        bus.step   = 1'b1;
      end
      tick();
      idle_inputs();
      ref_shift(m, si);
      check_state("seq_shift", k < a, k == a);
    end
    bus.ld   = 1'b1;
    bus.step = 1'b1;
    tick();
    idle_inputs();
    check_state("seq_end", 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    do_reset();

    do_load(8'hB4, 1'b0);
    run_seq(3'b010, 3, -1, 1'b0);
    check_eq("asr_final", 32'(bus.par_out), 32'h0000_00F6);
    check_eq("asr_ser",   32'(bus.ser_out), 32'h1);

    do_load(8'h0F, 1'b0);
    run_seq(3'b000, 4, 1, 1'b0);
    check_eq("lsl_fill1", 32'(bus.par_out), 32'h0000_00FF);
    do_load(8'h0F, 1'b0);
    run_seq(3'b000, 4, 0, 1'b0);
    check_eq("lsl_fill0", 32'(bus.par_out), 32'h0000_00F0);
    check_eq("lsl_ser0",  32'(bus.ser_out), 32'h0);

    do_load(8'h81, 1'b0);
    run_seq(3'b011, 1, -1, 1'b0);
    check_eq("rol1", 32'(bus.par_out), 32'h0000_0003);
    check_eq("rol1_ser", 32'(bus.ser_out), 32'h1);
    do_load(8'h81, 1'b0);
    run_seq(3'b100, 8, -1, 1'b0);
    check_eq("ror8", 32'(bus.par_out), 32'h0000_0081);
    do_load(8'h81, 1'b0);
    run_seq(3'b011, 9, -1, 1'b0);
    check_eq("rol9", 32'(bus.par_out), 32'h0000_0003);

    do_load(8'h3C, 1'b0);
    run_seq(3'b000, 0, -1, 1'b0);
    do_load(8'hA7, 1'b1);

    do_load(8'hB4, 1'b0);
    run_seq(3'b010, 3, -1, 1'b1);
    check_eq("disturb_final", 32'(bus.par_out), 32'h0000_00F6);

    do_load(8'h01, 1'b0);
    for (int i = 0; i < 3; i++) do_step(3'b011);
    check_eq("step_final", 32'(bus.par_out), 32'h0000_0008);
    run_seq(3'b101, 4, -1, 1'b0);
    check_eq("hold_final", 32'(bus.par_out), 32'h0000_0008);

    // Reset lands on the third shift edge of an LSR sequence.
    do_load(8'hFF, 1'b0);
    bus.start = 1'b1;
    bus.mode  = 3'b001;
    bus.amt   = AMT_W'(6);
    tick();
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      logic si;
      si = 1'($urandom);
      bus.ser_in = si;
      tick();
      ref_shift(3'b001, si);
      check_state("pre_rst", 1'b1, 1'b0);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_data = '0;
    m_ser  = 1'b0;
    check_state("rst_mid", 1'b0, 1'b0);
    do_load(8'hC3, 1'b0);
    run_seq(3'b100, 3, -1, 1'b0);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0:       do_load(W'($urandom), 1'($urandom));
        1:       do_step(3'($urandom));
        default: run_seq(3'($urandom), int'($urandom_range(0, 11)), -1, 1'($urandom));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/shift_engine.md
# shift_engine

Parametrised multi-mode shift engine: a WIDTH-bit register loaded in parallel, then shifted a programmed number of positions in one of five modes under a start/busy/done handshake. It also supports a single-step shift while idle. It sits alongside the multiplier/divider datapaths as the general shift resource and replaces fixed left-shift registers where variable amounts, direction or rotation are needed.

## Interface
Parameters:
- WIDTH, 16, data width in bits (≥2)
- AMT_W, $clog2(WIDTH)+1, width of the shift-amount port; amounts 0..WIDTH must be representable

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous reset, active-low: one clock; reset is synchronous and active-low
- ld  input  1  parallel load request
- par_in  input  WIDTH  parallel load data
- start  input  1  begin a programmed shift sequence
- amt  input  AMT_W  number of positions to shift, sampled with start
- mode  input  3  000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101–111 hold
- step  input  1  single one-position shift while idle, using live mode
- ser_in  input  1  serial fill bit for LSL/LSR, sampled every shift edge
- par_out  output  WIDTH  register contents
- ser_out  output  1  last bit shifted out (registered)
- MSB_out  output  1  par_out[WIDTH-1]
- LSB_out  output  1  par_out[0]
- busy  output  1  high while a sequence is running
- done  output  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, SHIFT, DONE. Counter cnt (AMT_W bits); latched mode register mode_q.
- IDLE, priority ld > start > step:
  - ld: par_out ← par_in.
  - start: mode_q ← mode, cnt ← amt. Go to SHIFT if amt≠0, else to DONE.
  - step: one shift using live mode; no done pulse.
- SHIFT: each edge performs one shift with mode_q and decrements cnt. The edge where cnt goes 1→0 moves to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. ld/start/step in DONE are ignored.
- ld, start and step are ignored while busy (SHIFT).
- Per-shift rules:
  - LSL: {d[W-2:0], ser_in}; ser_out ← d[W-1].
  - LSR: {ser_in, d[W-1:1]}; ser_out ← d[0].
  - ASR: {d[W-1], d[W-1:1]}; ser_out ← d[0]; ser_in ignored.
  - ROL: {d[W-2:0], d[W-1]}; ser_out ← d[W-1].
  - ROR: {d[0], d[W-1:1]}; ser_out ← d[0].
  - Hold codes: data and ser_out unchanged; counting still proceeds.
- amt > WIDTH is legal: shifts continue bit by bit (logical shifts saturate to ser_in fill; rotates wrap modulo WIDTH).
- ser_out changes only on an actual shift edge; a load does not change it.

## Timing
- Reset (rst=0 at an edge): par_out=0, ser_out=0, busy=0, done=0, cnt=0, mode_q=0, state IDLE. Reset wins over everything, including mid-sequence.
- start is sampled at edge E0. Shifts occur at edges E1..E_amt. busy is high from after E0 through E_amt. done is high between E_amt and E_amt+1. busy and done are never high together.
- amt=0: done is high between E0 and E1; busy stays 0; data is unchanged.
- step or ld takes effect at the same edge that samples it (1-cycle latency).
- A new start is accepted in the cycle after done.
- busy and done are registered outputs. MSB_out and LSB_out are combinational from par_out.

## Test plan
(All scenarios use WIDTH=8.)
- Load then ASR: ld par_in=0xB4; start mode=010 amt=3 -> par_out 0xDA, 0xED, 0xF6 on E1..E3; ser_out=1 after E3; done high one cycle after E3.
- LSL with fill: load 0x0F; LSL amt=4, ser_in=1 -> 0xFF. Repeat with ser_in=0 -> 0xF0, ser_out=0.
- Rotations: load 0x81; ROL amt=1 -> 0x03, ser_out=1. Load 0x81; ROR amt=8 -> 0x81, busy for 8 cycles. Load 0x81; ROL amt=9 -> 0x03.
- Boundaries: start amt=0 -> done next cycle, busy never high, par_out unchanged. ld=1 and start=1 together in IDLE -> load only, no sequence. ld=1 with par_in=0x55 during SHIFT -> ignored, sequence result unaffected.
- Step mode: load 0x01; step with mode=011 three times -> 0x02, 0x04, 0x08; done stays 0. Mode=101 for one sequence -> data held, done still pulses after amt cycles.
- Reset mid-operation: LSR amt=6 on 0xFF; rst=0 at E3 -> next cycle par_out=0, ser_out=0, busy=0, done=0. A new start after rst returns high works normally.
